// File: rtl/io_display_driver.sv
// Binary-to-decimal seven-segment driver: double-dabble conversion, one bit per clock.
// Optional two's-complement display with leading minus sign via DISPLAY_SIGNED_EN.
//
// state  | meaning
// IDLE   | watch value; start a conversion when it differs from shadow or after reset
// CONV   | 32 shift-and-add-3 steps of {bcd, bin}
// UPDATE | latch segment patterns and overflow from the finished BCD digits
module io_display_driver #(
    parameter int DIGITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           value,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  busy,
    output logic                  overflow
);

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

    state_t               state_q;
    logic [31:0]          shadow_q;
    logic                 fresh_q;
    logic [31:0]          bin_q;
    logic [39:0]          bcd_q;
    logic [4:0]           cnt_q;
    logic                 neg_q;
    logic [7*DIGITS-1:0]  hex_q;
    logic                 busy_q;
    logic                 overflow_q;

    logic                 neg_d;
    logic [31:0]          mag_d;
    logic [38:0]          bcd_adj;
    logic [7*DIGITS-1:0]  hex_d;
    logic                 overflow_d;
    logic [3:0]           msd;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    always_comb begin
`ifdef DISPLAY_SIGNED_EN
        neg_d = value[31];
        mag_d = value[31] ? (~value + 32'd1) : value;
`else
        neg_d = 1'b0;
        mag_d = value;
`endif
    end

    // The top digit of a 32-bit magnitude never exceeds 4, so it needs no correction.
    always_comb begin
        bcd_adj = bcd_q[38:0];
        for (int i = 0; i < 9; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        overflow_d = 1'b0;
        msd        = 4'd0;
        hex_d      = '1;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                if (i >= DIGITS)
                    overflow_d = 1'b1;
                else
                    msd = 4'(i);
            end
        end
        if (neg_q && bcd_q[4*(DIGITS-1) +: 4] != 4'd0)
            overflow_d = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (overflow_d)
                hex_d[7*i +: 7] = 7'h06;
            else if (4'(i) <= msd)
                hex_d[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
            else if (neg_q && 4'(i) == msd + 4'd1)
                hex_d[7*i +: 7] = 7'h3F;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            fresh_q    <= 1'b1;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            hex_q      <= '1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fresh_q || value != shadow_q) begin
                        shadow_q <= value;
                        fresh_q  <= 1'b0;
                        bin_q    <= mag_d;
                        neg_q    <= neg_d;
                        bcd_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CONV;
                    end
                end
                CONV: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q, 1'b0};
                    cnt_q          <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31)
                        state_q <= UPDATE;
                end
                UPDATE: begin
                    hex_q      <= hex_d;
                    overflow_q <= overflow_d;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hex      = hex_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_io_display_driver.sv
// Scoreboard bench for io_display_driver: a cycle-level acceptance model pushes expected
// displays (computed with decimal arithmetic); a monitor pops them when busy drops.
module tb_io_display_driver;

    localparam int DIGITS = 8;
    localparam int W      = 7 * DIGITS;
    localparam int LAT    = 33;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   value = '0;
    logic [W-1:0]  hex;
    logic          busy;
    logic          overflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W:0]    exp_q[$];
    logic [31:0]   m_shadow = '0;
    bit            m_fresh  = 1'b1;
    int            m_busy   = 0;

    io_display_driver #(.DIGITS(DIGITS)) dut (
        .clock    (clock),
        .reset    (reset),
        .value    (value),
        .hex      (hex),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected {overflow, hex} from the decimal value, independent of any BCD mechanics.
    function automatic logic [W:0] ref_display(input logic [31:0] v);
        longint unsigned mag;
        longint unsigned p;
        bit              neg;
        bit              ovf;
        int              nd;
        logic [W-1:0]    h;
        neg = 1'b0;
        mag = {32'd0, v};
`ifdef DISPLAY_SIGNED_EN
        if (v[31]) begin
            neg = 1'b1;
            mag = 64'h1_0000_0000 - {32'd0, v};
        end
`endif
        nd = 1;
        p  = 10;
        while (p <= mag) begin
            nd++;
            p = p * 10;
        end
        ovf = (nd > DIGITS) || (neg && nd >= DIGITS);
        h   = '1;
        p   = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf)
                h[7*i +: 7] = 7'h06;
            else if (i < nd)
                h[7*i +: 7] = seg_of(int'((mag / p) % 10));
            else if (neg && i == nd)
                h[7*i +: 7] = 7'h3F;
            p = p * 10;
        end
        return {ovf, h};
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_shadow = '0;
            m_fresh  = 1'b1;
            m_busy   = 0;
            exp_q.delete();
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (m_fresh || value !== m_shadow) begin
            m_shadow = value;
            m_fresh  = 1'b0;
            exp_q.push_back(ref_display(value));
            m_busy   = LAT;
        end
    end

    logic       busy_prev = 1'b0;
    logic [W:0] hold;
    logic [W:0] e;

    always @(negedge clock) begin
        if (!reset) begin
            busy_prev = 1'b0;
            hold      = {overflow, hex};
        end else begin
            n_cmp++;
            if (busy !== (m_busy > 0)) begin
                n_bad++;
                $display("FAIL busy_timing: got %b want %b at %0t", busy, (m_busy > 0), $time);
            end
            if (busy) begin
                n_cmp++;
                if ({overflow, hex} !== hold) begin
                    n_bad++;
                    $display("FAIL display_hold: got %h want %h at %0t", {overflow, hex}, hold, $time);
                end
            end
            if (busy_prev && !busy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_update: got %h want none at %0t", {overflow, hex}, $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({overflow, hex} !== e) begin
                        n_bad++;
                        $display("FAIL display: got %h want %h at %0t", {overflow, hex}, e, $time);
                    end
                end
            end
            if (!busy)
                hold = {overflow, hex};
            busy_prev = busy;
        end
    end

    task automatic check(input string name, input logic [W:0] got, input logic [W:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while ((m_busy > 0 || m_fresh || value !== m_shadow || exp_q.size() != 0) && t < 300) begin
            @(negedge clock);
            t++;
        end
        @(negedge clock);
        n_cmp++;
        if (t >= 300) begin
            n_bad++;
            $display("FAIL timeout_%s: got %0d cycles want < 300", tag, t);
        end
    endtask

    logic [31:0] dirs[8] = '{32'd1234, 32'd99999999, 32'd100000000, 32'hFFFF_FFFF,
                             32'hFA0A_1F01, 32'd0, 32'd9, 32'h8000_0000};

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_hex", {1'b0, hex}, {1'b0, {W{1'b1}}});
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b1;
        wait_done("first");
        check("zero_disp", {overflow, hex}, {1'b0, {(W-7){1'b1}}, 7'h40});

        foreach (dirs[i]) begin
            @(negedge clock);
            value = dirs[i];
            wait_done("directed");
        end

        @(negedge clock);
        value = 32'd5;
        wait_done("five");
        value = 32'd7;
        repeat (4) @(negedge clock);
        value = 32'd5;
        repeat (10) @(negedge clock);
        check("toggle_busy", busy, 1);
        wait_done("toggle");

        value = 32'd3;
        repeat (5) @(negedge clock);
        value = 32'd8;
        wait_done("midchange");

        value = 32'd123456;
        repeat (11) @(negedge clock);
        check("pre_abort_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_hex", {1'b0, hex}, {1'b0, {W{1'b1}}});
        check("abort_ovf", overflow, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        wait_done("after_abort");

        for (int n = 0; n < 150; n++) begin
            @(negedge clock);
            case ($urandom_range(0, 3))
                0: value = $urandom;
                1: value = $urandom_range(0, 9999);
                2: value = $urandom_range(90000000, 110000000);
                default: value = 32'd0 - $urandom_range(1, 99999999);
            endcase
            repeat ($urandom_range(0, 40)) @(negedge clock);
        end
        wait_done("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/io_display_driver.md
# io_display_driver

Downstream consumer of the processor's 32-bit output registers (out1/out2/out3): converts one register value to decimal and drives a bank of active-low seven-segment digits on the board. Conversion is iterative, using shift-and-add-3 (double-dabble) at one bit per cycle. It runs automatically whenever the observed value changes. One instance is placed per output register, clocked by the divided processor clock.

## Interface
Parameters:
- DIGITS, 8, number of seven-segment digits driven; legal range 4..10

Ports:
- clock  in  1  divided processor clock; all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- value  in  32  output-register value to display; sampled only when idle
- hex  out  7*DIGITS  segment patterns, digit i at hex[7*i+6:7*i]; bit0=a … bit6=g; active-low
- busy  out  1  high while a conversion is in progress (CONV or UPDATE)
- overflow  out  1  high while the displayed value does not fit in DIGITS digits

## Operation
- Internal registers:
  - shadow[31:0]: last value accepted for conversion.
  - fresh: set by reset.
  - bin[31:0]: shift source.
  - bcd[39:0]: ten BCD digits.
  - cnt[4:0]: shift counter.
  - neg: sign flag.
- FSM states:
  - IDLE: if fresh=1 or value≠shadow, then shadow←value, clear fresh, load bin←magnitude(value), bcd←0, cnt←0, go to CONV. Otherwise stay in IDLE.
  - CONV: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,bin} left by 1. cnt++. After the shift with cnt=31, go to UPDATE.
  - UPDATE: compute the display from bcd and write hex and overflow, then return to IDLE.
- Magnitude:
  - Unsigned conversion: magnitude = value.
  - With signed display, see Configuration.
- Overflow: overflow=1 when any BCD digit at index ≥ DIGITS is nonzero. When neg=1, overflow is also set if digit DIGITS-1 is nonzero, because no position remains for the sign.
- Display rules when not overflowed:
  - Leading-zero blanking: digits above the most significant nonzero digit show blank.
  - Magnitude 0 shows "0" on digit 0; all other digits blank.
  - If neg=1, the digit immediately left of the most significant nonzero digit shows minus.
- Display on overflow: every digit shows "E".
- Segment codes (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F, minus=3F, E=06.
- Input handling:
  - Changes of value during CONV/UPDATE are not observed.
  - A value that differs from shadow on return to IDLE starts a new conversion.
  - A value that toggles away and back within one conversion causes no second conversion.

## Timing
- Reset asserted:
  - hex = all 7F (all digits blank), busy=0, overflow=0.
  - shadow=0, fresh=1, state=IDLE.
- Conversion latency, counting from the edge k at which IDLE accepts a value:
  - busy=1 after edge k.
  - CONV occupies edges k+1..k+32.
  - UPDATE writes hex and overflow at edge k+33; busy=0 after edge k+33.
  - Total latency is 33 cycles. Back-to-back conversions start no earlier than edge k+34.
- First conversion after reset release starts at the first rising edge, even when value=0.
- hex and overflow change only at the UPDATE edge. They hold their previous contents throughout CONV; no intermediate patterns appear.
- Reset mid-conversion aborts immediately: outputs return to reset values, and a fresh conversion of the current value follows release.

## Configuration
- DISPLAY_SIGNED_EN defined:
  - value is two's complement. neg=value[31]; magnitude = neg ? (~value+1) : value.
  - 0x80000000 converts as magnitude 2147483648.
  - Minus sign and sign-overflow rules apply.
- DISPLAY_SIGNED_EN undefined:
  - neg is tied to 0; value is treated as unsigned 0..4294967295.
  - Minus code is never emitted.

## Test plan
- Reset then release with value=0 → hex all 7F during reset. 33 cycles after the first edge, digit0=40 and digits1..7=7F; busy high for exactly 33 cycles; overflow=0.
- value=1234 (DIGITS=8) → digits3..0 = 79,24,30,19; digits7..4 = 7F; no hex change before the UPDATE edge.
- value=99999999 → all eight digits 10, overflow=0. Then value=100000000 → all digits 06, overflow=1.
- DISPLAY_SIGNED_EN, value=0xFFFFFFFF → digit0=79, digit1=3F, rest 7F. value=0xFA0A1F01 (-99999999) → overflow=1, all 06.
- value changes 5→7→5 within one conversion window → no second conversion started. Change 5→7 mid-conversion → display shows 5, then 7 after a further 33 cycles from the acceptance edge.
- Assert reset 10 cycles into CONV → busy=0 and hex all 7F immediately. After release, a conversion of the current value completes 33 cycles after the first edge.
